// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: free-running x/y counters with registered sync and active-video flags.
// Optional `VGA_SYNC_GEN_FRAME_TICK_EN adds a one-cycle frame_tick output aligned with (0,0).
`timescale 1ns/1ps

module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0
) (
    input  logic       px_clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] x_px,
    output logic [9:0] y_px,
`ifdef VGA_SYNC_GEN_FRAME_TICK_EN
    output logic       frame_tick,
`endif
    output logic       activevideo
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Bounds are held in 11 bits so a 1024-wide total still compares correctly.
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1024) begin : g_h_total_err
        $error("vga_sync_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_err
        $error("vga_sync_gen: V_TOTAL exceeds 1024");
    end

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       activevideo_q, activevideo_d;
`ifdef VGA_SYNC_GEN_FRAME_TICK_EN
    logic       frame_tick_q, frame_tick_d;
`endif

    // Next-state counters, and flags decoded from those next values so outputs stay aligned.
    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = 10'd0;
            if (y_q == V_LAST) begin
                y_d = 10'd0;
            end else begin
                y_d = y_q + 10'd1;
            end
        end else begin
            y_d = y_q;
        end

        activevideo_d = ({1'b0, x_d} < H_ACT) && ({1'b0, y_d} < V_ACT);

        if (({1'b0, x_d} >= HS_START) && ({1'b0, x_d} < HS_END)) begin
            hsync_d = HS_POL;
        end else begin
            hsync_d = ~HS_POL;
        end

        if (({1'b0, y_d} >= VS_START) && ({1'b0, y_d} < VS_END)) begin
            vsync_d = VS_POL;
        end else begin
            vsync_d = ~VS_POL;
        end
`ifdef VGA_SYNC_GEN_FRAME_TICK_EN
        frame_tick_d = (x_d == 10'd0) && (y_d == 10'd0);
`endif
    end

    // State and output registers; reset presents the (0,0) pixel with syncs deasserted.
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            activevideo_q <= 1'b1;
`ifdef VGA_SYNC_GEN_FRAME_TICK_EN
            frame_tick_q  <= 1'b0;
`endif
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            activevideo_q <= activevideo_d;
`ifdef VGA_SYNC_GEN_FRAME_TICK_EN
            frame_tick_q  <= frame_tick_d;
`endif
        end
    end

    assign x_px        = x_q;
    assign y_px        = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign activevideo = activevideo_q;
`ifdef VGA_SYNC_GEN_FRAME_TICK_EN
    assign frame_tick  = frame_tick_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a default 640x480 instance and a tiny active-high-sync
// instance (15x8 raster) so frame wrap and vsync are reached in a short run.
`timescale 1ns/1ps

module tb_vga_sync_gen;

    localparam int N_CYC = 2500;

    logic       px_clk = 1'b0;
    logic       reset  = 1'b1;

    logic       hs_a, vs_a, av_a;
    logic [9:0] x_a, y_a;
    logic       hs_b, vs_b, av_b;
    logic [9:0] x_b, y_b;
`ifdef VGA_SYNC_GEN_FRAME_TICK_EN
    logic       ft_a, ft_b;
`endif

    always #20 px_clk = ~px_clk;

    vga_sync_gen u_dut_a (
        .px_clk      (px_clk),
        .reset       (reset),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .x_px        (x_a),
        .y_px        (y_a),
`ifdef VGA_SYNC_GEN_FRAME_TICK_EN
        .frame_tick  (ft_a),
`endif
        .activevideo (av_a)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut_b (
        .px_clk      (px_clk),
        .reset       (reset),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .x_px        (x_b),
        .y_px        (y_b),
`ifdef VGA_SYNC_GEN_FRAME_TICK_EN
        .frame_tick  (ft_b),
`endif
        .activevideo (av_b)
    );

    typedef struct {
        int         idx;
        logic [9:0] xa, ya;
        logic       hsa, vsa, ava, fta;
        logic [9:0] xb, yb;
        logic       hsb, vsb, avb, ftb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_low_line0 = 0;
    int   av_frame_b   = 0;
    int   vs_frame_b   = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30) $display("FAIL %s cycle %0d got %0d expected %0d", name, idx, act, req);
        end
    endtask

    // Expected values from the hand-written timing constants of each raster.
    function automatic exp_t model(input int n);
        exp_t e;
        int xa, ya, xb, yb;
        xa = n % 800;
        ya = (n / 800) % 525;
        xb = n % 15;
        yb = (n / 15) % 8;
        e.idx = n;
        e.xa  = 10'(xa);
        e.ya  = 10'(ya);
        e.ava = (xa < 640) && (ya < 480);
        e.hsa = !((xa >= 656) && (xa < 752));
        e.vsa = !((ya >= 490) && (ya < 492));
        e.fta = (n > 0) && (xa == 0) && (ya == 0);
        e.xb  = 10'(xb);
        e.yb  = 10'(yb);
        e.avb = (xb < 8) && (yb < 4);
        e.hsb = (xb >= 10) && (xb < 13);
        e.vsb = (yb >= 5) && (yb < 7);
        e.ftb = (n > 0) && (xb == 0) && (yb == 0);
        return e;
    endfunction

    // Monitor: pop one expected record per cycle and compare away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge px_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("x_a", e.idx, 32'(x_a), 32'(e.xa));
                chk("y_a", e.idx, 32'(y_a), 32'(e.ya));
                chk("hsync_a", e.idx, 32'(hs_a), 32'(e.hsa));
                chk("vsync_a", e.idx, 32'(vs_a), 32'(e.vsa));
                chk("active_a", e.idx, 32'(av_a), 32'(e.ava));
                chk("x_b", e.idx, 32'(x_b), 32'(e.xb));
                chk("y_b", e.idx, 32'(y_b), 32'(e.yb));
                chk("hsync_b", e.idx, 32'(hs_b), 32'(e.hsb));
                chk("vsync_b", e.idx, 32'(vs_b), 32'(e.vsb));
                chk("active_b", e.idx, 32'(av_b), 32'(e.avb));
`ifdef VGA_SYNC_GEN_FRAME_TICK_EN
                if (e.idx > 0) begin
                    chk("frame_tick_a", e.idx, 32'(ft_a), 32'(e.fta));
                    chk("frame_tick_b", e.idx, 32'(ft_b), 32'(e.ftb));
                end
`endif
                if (e.idx < 800 && hs_a == 1'b0) hs_low_line0++;
                if (e.idx < 120 && av_b == 1'b1) av_frame_b++;
                if (e.idx < 120 && vs_b == 1'b1) vs_frame_b++;
            end
        end
    end

    // Stimulus: reset, push the expected raster per cycle, then an asynchronous mid-line reset.
    initial begin
        int waited;
        repeat (3) @(posedge px_clk);
        @(negedge px_clk);
        chk("rst_x_a", 0, 32'(x_a), 32'd0);
        chk("rst_y_a", 0, 32'(y_a), 32'd0);
        chk("rst_av_a", 0, 32'(av_a), 32'd1);
        chk("rst_hs_a", 0, 32'(hs_a), 32'd1);
        chk("rst_vs_a", 0, 32'(vs_a), 32'd1);
        chk("rst_hs_b", 0, 32'(hs_b), 32'd0);
        chk("rst_vs_b", 0, 32'(vs_b), 32'd0);

        @(posedge px_clk);
        #1 reset = 1'b0;
        exp_q.push_back(model(0));
        for (int n = 1; n < N_CYC; n++) begin
            @(posedge px_clk);
            exp_q.push_back(model(n));
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge px_clk);
            waited++;
        end
        chk("scoreboard_drain", waited, 32'(exp_q.size()), 32'd0);

        chk("hsync_low_width", 0, 32'(hs_low_line0), 32'd96);
        chk("active_count_b", 0, 32'(av_frame_b), 32'd32);
        chk("vsync_width_b", 0, 32'(vs_frame_b), 32'd30);

        repeat (137) @(posedge px_clk);
        #7 reset = 1'b1;
        #1;
        chk("async_x_a", 1, 32'(x_a), 32'd0);
        chk("async_y_a", 1, 32'(y_a), 32'd0);
        chk("async_av_a", 1, 32'(av_a), 32'd1);
        chk("async_hs_a", 1, 32'(hs_a), 32'd1);
        chk("async_vs_a", 1, 32'(vs_a), 32'd1);
        chk("async_x_b", 1, 32'(x_b), 32'd0);
        chk("async_y_b", 1, 32'(y_b), 32'd0);
        chk("async_av_b", 1, 32'(av_b), 32'd1);

        @(posedge px_clk);
        #1 reset = 1'b0;
        @(posedge px_clk);
        #1;
        chk("restart_x_a", 1, 32'(x_a), 32'd1);
        chk("restart_y_a", 1, 32'(y_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
